addsub_digit_serial: RTL and testbench
======================================

Name: addsub_digit_serial

Overview:
- Parametrised, digit-serial two's-complement adder/subtractor. Next generation of the team's fixed 4-bit ripple add/sub.
- Accepts WIDTH-bit operands and a sign (mode) bit over a valid/ready handshake.
- Processes DIGIT bits per clock through a registered carry, then presents {carry-out, sum} on an output handshake.
- Used where area matters more than latency, e.g. in the arithmetic benchmark datapaths.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥1 and a multiple of DIGIT.
- DIGIT, 2, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/mode presented.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sign  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH+1  s[WIDTH-1:0] = sum/difference mod 2^WIDTH; s[WIDTH] = carry-out. For subtract, carry-out 1 means no borrow.

Behaviour:
- Reset (rst high at an edge): state=IDLE, in_ready=1, out_valid=0, s=0, carry=0, digit counter=0.
- Reset mid-operation aborts the operation. No output is produced for it.
- Arithmetic: s = A + (B XOR {WIDTH{sign}}) + sign, computed LSB digit first.
- Carry register is seeded with sign at accept.
- States and transitions:
  - IDLE: in_ready=1. On in_valid & in_ready at an edge: latch a, b XOR sign-mask, carry←sign, count←0, go BUSY. Input values outside the accept edge are don't-care.
  - BUSY: in_ready=0. Each edge adds digit [count*DIGIT +: DIGIT] of A and B' plus carry, writes that sum digit into the result register, updates carry and increments count. After N = WIDTH/DIGIT BUSY edges: s[WIDTH]←final carry, go DONE.
  - DONE: out_valid=1, in_ready=0, s stable. On out_valid & out_ready at an edge: go IDLE; out_valid=0 from the next cycle.
- Latency: accept at edge t → out_valid high in cycle after edge t+N.
- Minimum issue interval: N+2 cycles (no accept in DONE; no bypass of IDLE).
- out_ready while not DONE is ignored. in_valid while not IDLE is ignored and not queued.
- s holds its last completed value after handoff and through IDLE/BUSY, until overwritten. Partial digits may be visible in s during BUSY; only the DONE value is defined.
- DIGIT = WIDTH: single BUSY cycle, N = 1. WIDTH = 1 is legal.
- Counter width: clog2(N) bits, minimum 1. No wrap beyond N−1.

Optional Feature:
- Macro ADDSUB_OVF_FLAG_EN.
- Defined: adds output port ovf (output, 1 bit), the signed overflow flag.
  - ovf = carry into MSB XOR carry-out, registered with s on entry to DONE.
  - Reset 0; held alongside s.
- Undefined: port ovf absent. No overflow logic is generated. All other behaviour is identical.

Test Plan (WIDTH=8, DIGIT=2 unless stated):
- Add: a=0x5A, b=0x33, sign=0 → s=0x08D, out_valid exactly 4 cycles after the accept edge, in_ready low throughout.
- Subtract with borrow: a=0x01, b=0x02, sign=1 → s=0x0FF (carry 0); a=0x10, b=0x01, sign=1 → s=0x10F.
- Wrap/overflow: a=0xFF, b=0x01, sign=0 → s=0x100. With ADDSUB_OVF_FLAG_EN, a=0x7F, b=0x01, sign=0 → s=0x080, ovf=1; a=0x80, b=0x01, sign=1 → s=0x17F, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → s and out_valid stable, in_ready=0, new in_valid ignored. Then raise out_ready → IDLE and in_ready=1 the next cycle.
- Reset mid-BUSY: assert rst at the 2nd BUSY edge → out_valid=0, s=0, in_ready=1 the next cycle. A fresh op 0x22+0x11 then yields s=0x033.
- Parameter sweep: DIGIT=1, 4, 8 with WIDTH=8, plus WIDTH=16/DIGIT=4. Random operands vs. reference model (a ± b) & mask plus carry; latency = WIDTH/DIGIT each time.

Source files
------------

// File: rtl/addsub_digit_serial.sv
// addsub_digit_serial: digit-serial two's-complement adder/subtractor.
// Operands are accepted over a valid/ready handshake. They are then summed
// DIGIT bits per clock, LSB digit first, through a registered carry. The
// result {carry-out, sum} is held on an output handshake until it is taken.
// Optional build macro ADDSUB_OVF_FLAG_EN adds the signed overflow output ovf.
//
// Handshake semantics (both sides): a transfer happens at a rising clk edge
// where valid and ready are both high. valid is never withdrawn until that
// transfer, and the data under it is stable. in_ready is high only in IDLE.
// out_valid is high only in DONE. Only the in_valid & in_ready edge samples
// a, b and sign; their values at other edges are not used.
module addsub_digit_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   s,
`ifdef ADDSUB_OVF_FLAG_EN
    output logic             ovf,
`endif
    output logic [1:0]       dbg_state
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;      // B with the subtract mask already applied
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] a_d;
    logic [DIGIT-1:0] b_d;
    logic [DIGIT:0]   dsum;
    logic             last;

    // Select the current operand digits and form the digit sum with carry-in.
    always_comb begin
        a_d = '0;
        b_d = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                a_d = a_r[i*DIGIT +: DIGIT];
                b_d = b_r[i*DIGIT +: DIGIT];
            end
        end
        dsum = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, carry};
        last = (cnt == CW'(N - 1));
    end

    // Control FSM, digit datapath and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
`ifdef ADDSUB_OVF_FLAG_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b ^ {WIDTH{sign}};
                        carry <= sign;   // +1 completes the two's-complement negate
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < N; i++) begin
                        if (cnt == CW'(i)) begin
                            s[i*DIGIT +: DIGIT] <= dsum[DIGIT-1:0];
                        end
                    end
                    carry <= dsum[DIGIT];
                    if (last) begin
                        s[WIDTH] <= dsum[DIGIT];
`ifdef ADDSUB_OVF_FLAG_EN
                        // Carry into the MSB is recovered from the MSB sum bit.
                        ovf <= a_d[DIGIT-1] ^ b_d[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
`endif
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_addsub_digit_serial.sv
// tb_addsub_digit_serial: scoreboard bench for addsub_digit_serial.
// Main instance WIDTH=8/DIGIT=2, plus a sweep of other WIDTH/DIGIT pairs.
// Build with +define+ADDSUB_OVF_FLAG_EN to also exercise the ovf output.
module tb_addsub_digit_serial;

    localparam int W = 8;
    localparam int D = 2;
    localparam int N = W / D;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sign;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   s;
    logic [1:0]   dbg_state;
`ifdef ADDSUB_OVF_FLAG_EN
    logic         ovf;
`endif

    addsub_digit_serial #(.WIDTH(W), .DIGIT(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sign      (sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
`ifdef ADDSUB_OVF_FLAG_EN
        .ovf       (ovf),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- sweep DUTs ----------------
    logic [15:0] sw_a   [4];
    logic [15:0] sw_b   [4];
    logic        sw_sign[4];
    logic        sw_iv  [4];
    logic        sw_or  [4];
    logic        sw_ir  [4];
    logic        sw_ov  [4];
    logic [16:0] sw_s   [4];
    logic [1:0]  sw_st  [4];
    logic        sw_ovf [4];

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int GW = (g == 3) ? 16 : 8;
        localparam int GD = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 4;
        logic [GW:0] s_w;
        logic        ir_w;
        logic        ov_w;
        logic [1:0]  st_w;
`ifdef ADDSUB_OVF_FLAG_EN
        logic        ovf_w;
`endif
        addsub_digit_serial #(.WIDTH(GW), .DIGIT(GD)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (sw_iv[g]),
            .in_ready  (ir_w),
            .a         (sw_a[g][GW-1:0]),
            .b         (sw_b[g][GW-1:0]),
            .sign      (sw_sign[g]),
            .out_valid (ov_w),
            .out_ready (sw_or[g]),
            .s         (s_w),
`ifdef ADDSUB_OVF_FLAG_EN
            .ovf       (ovf_w),
`endif
            .dbg_state (st_w)
        );
        assign sw_s[g]  = 17'(s_w);
        assign sw_ir[g] = ir_w;
        assign sw_ov[g] = ov_w;
        assign sw_st[g] = st_w;
`ifdef ADDSUB_OVF_FLAG_EN
        assign sw_ovf[g] = ovf_w;
`else
        assign sw_ovf[g] = 1'b0;
`endif
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [W:0]  exp_q[$];
    logic        exp_ovf_q[$];
    logic [16:0] sw_exp_q[$];
    logic        sw_exp_ovf_q[$];

    // Reference: add is plain unsigned sum; subtract is difference mod 2^w
    // with carry-out meaning "no borrow" (x >= y).
    function automatic logic [31:0] ref_res(input logic [31:0] x, input logic [31:0] y,
                                            input logic sg, input int w);
        logic [31:0] m;
        m = (32'd1 << w) - 32'd1;
        if (!sg) return x + y;
        return (((x >= y) ? 32'd1 : 32'd0) << w) | ((x - y) & m);
    endfunction

    // Reference signed overflow: true result outside the w-bit signed range.
    function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y,
                                     input logic sg, input int w);
        int half, sx, sy, r;
        half = 1 << (w - 1);
        sx = (int'(x) >= half) ? int'(x) - 2 * half : int'(x);
        sy = (int'(y) >= half) ? int'(y) - 2 * half : int'(y);
        r  = sg ? sx - sy : sx + sy;
        return (r >= half) || (r < -half);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sg,
                         input int hold);
        int         lat;
        logic [31:0] r;
        logic [W:0] exp_v;
        logic [W:0] held;
        logic       exp_o;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL op_in_ready_idle: got %b expected 1", in_ready);
        end
        a = x; b = y; sign = sg; in_valid = 1'b1;
        r = ref_res(32'(x), 32'(y), sg, W);
        exp_q.push_back(r[W:0]);
        exp_ovf_q.push_back(ref_ovf(32'(x), 32'(y), sg, W));
        @(negedge clk);            // accept edge has passed
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sign = 1'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_in_ready: got %b expected 0", in_ready);
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== N) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d", lat, N);
        end
        if (out_valid === 1'b1 && exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            exp_o = exp_ovf_q.pop_front();
            checks++;
            if (s !== exp_v) begin
                errors++;
                $display("FAIL result a=%h b=%h sign=%b: got %h expected %h", x, y, sg, s, exp_v);
            end
`ifdef ADDSUB_OVF_FLAG_EN
            checks++;
            if (ovf !== exp_o) begin
                errors++;
                $display("FAIL ovf a=%h b=%h sign=%b: got %b expected %b", x, y, sg, ovf, exp_o);
            end
`endif
        end
        held = s;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;       // must be ignored while DONE
            a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || s !== held || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold: got ov=%b s=%h ir=%b expected ov=1 s=%h ir=0",
                         out_valid, s, in_ready, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);            // handoff edge has passed
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== held) begin
            errors++;
            $display("FAIL handoff: got ov=%b ir=%b s=%h expected ov=0 ir=1 s=%h",
                     out_valid, in_ready, s, held);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sign = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sw_iv[i] = 1'b0; sw_or[i] = 1'b0; sw_a[i] = '0; sw_b[i] = '0; sw_sign[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got ir=%b ov=%b s=%h st=%0d expected 1 0 0 0",
                     in_ready, out_valid, s, dbg_state);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sw_ir[i] !== 1'b1 || sw_ov[i] !== 1'b0 || sw_s[i] !== '0 || sw_st[i] !== 2'd0) begin
                errors++;
                $display("FAIL sweep_reset[%0d]: got ir=%b ov=%b s=%h st=%0d", i,
                         sw_ir[i], sw_ov[i], sw_s[i], sw_st[i]);
            end
        end
    endtask

    task automatic test_directed();
        do_op(8'h5A, 8'h33, 1'b0, 0);
        do_op(8'h01, 8'h02, 1'b1, 0);
        do_op(8'h10, 8'h01, 1'b1, 0);
        do_op(8'hFF, 8'h01, 1'b0, 0);
        do_op(8'h00, 8'h00, 1'b1, 0);
    endtask

`ifdef ADDSUB_OVF_FLAG_EN
    task automatic test_ovf();
        do_op(8'h7F, 8'h01, 1'b0, 0);
        do_op(8'h80, 8'h01, 1'b1, 0);
        do_op(8'h80, 8'h80, 1'b0, 0);
        do_op(8'h40, 8'h20, 1'b0, 0);
    endtask
`endif

    task automatic test_backpressure();
        do_op(8'hC3, 8'h3C, 1'b0, 5);
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        a = 8'hAA; b = 8'h55; sign = 1'b0; in_valid = 1'b1;
        @(negedge clk);            // accept edge
        in_valid = 1'b0;
        @(negedge clk);            // first BUSY edge
        rst = 1'b1;
        @(negedge clk);            // second BUSY edge, reset sampled
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || s !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy: got ov=%b s=%h ir=%b expected 0 000 1",
                     out_valid, s, in_ready);
        end
        do_op(8'h22, 8'h11, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 10; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
    endtask

    task automatic test_sweep(input int idx, input int w, input int d);
        int          n, lat;
        logic [31:0] m, x, y, r;
        logic        sg, exp_o;
        logic [16:0] exp_v;
        n = w / d;
        m = (32'd1 << w) - 32'd1;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                x = m; y = 32'd1; sg = 1'b0;
            end else if (k == 1) begin
                x = 32'd0; y = 32'd1; sg = 1'b1;
            end else begin
                x = $urandom & m; y = $urandom & m; sg = 1'($urandom_range(0, 1));
            end
            r = ref_res(x, y, sg, w);
            sw_exp_q.push_back(r[16:0]);
            sw_exp_ovf_q.push_back(ref_ovf(x, y, sg, w));
            @(negedge clk);
            sw_a[idx] = x[15:0]; sw_b[idx] = y[15:0]; sw_sign[idx] = sg; sw_iv[idx] = 1'b1;
            checks++;
            if (sw_ir[idx] !== 1'b1) begin
                errors++;
                $display("FAIL sweep_in_ready[%0d]: got %b expected 1", idx, sw_ir[idx]);
            end
            @(negedge clk);
            sw_iv[idx] = 1'b0;
            lat = 0;
            while (sw_ov[idx] !== 1'b1 && lat < 64) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat !== n) begin
                errors++;
                $display("FAIL sweep_latency[%0d]: got %0d expected %0d", idx, lat, n);
            end
            exp_v = sw_exp_q.pop_front();
            exp_o = sw_exp_ovf_q.pop_front();
            checks++;
            if (sw_s[idx] !== exp_v) begin
                errors++;
                $display("FAIL sweep_result[%0d] a=%h b=%h sign=%b: got %h expected %h",
                         idx, x, y, sg, sw_s[idx], exp_v);
            end
`ifdef ADDSUB_OVF_FLAG_EN
            checks++;
            if (sw_ovf[idx] !== exp_o) begin
                errors++;
                $display("FAIL sweep_ovf[%0d]: got %b expected %b", idx, sw_ovf[idx], exp_o);
            end
`endif
            sw_or[idx] = 1'b1;
            @(negedge clk);
            sw_or[idx] = 1'b0;
            checks++;
            if (sw_ov[idx] !== 1'b0 || sw_ir[idx] !== 1'b1) begin
                errors++;
                $display("FAIL sweep_handoff[%0d]: got ov=%b ir=%b expected 0 1",
                         idx, sw_ov[idx], sw_ir[idx]);
            end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_directed();
`ifdef ADDSUB_OVF_FLAG_EN
        test_ovf();
`endif
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        test_sweep(0, 8, 1);
        test_sweep(1, 8, 4);
        test_sweep(2, 8, 8);
        test_sweep(3, 16, 4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
